huffman_ctrl: RTL

Top-level sequencer for the Huffman encoder datapath. Counts incoming gray-level samples, runs the sort/combine merge rounds and the split rounds, then drives the DECODE and CODEV states. The encode-output register bank latches the code and mask words in DECODE and clears them in CODEV. The block's 3-bit `state` output is the single state bus consumed by the counter, sorter, combine/split units and the encode-output bank.

---
 rtl/huffman_pkg.sv | 16 +
 rtl/huff_sample_cnt.sv | 36 +++
 rtl/huffman_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared encodings and defaults for the Huffman encoder control path.
package huffman_pkg;

  localparam int unsigned NUM_SYMS_DEF    = 6;
  localparam int unsigned NUM_SAMPLES_DEF = 100;

  // State bus encodings; DECODE/CODEV are also decoded by the encode-output bank
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COUNT   = 3'd1;
  localparam logic [2:0] ST_SORT    = 3'd2;
  localparam logic [2:0] ST_COMBINE = 3'd3;
  localparam logic [2:0] ST_DECODE  = 3'd4;
  localparam logic [2:0] ST_CODEV   = 3'd5;
  localparam logic [2:0] ST_SPLIT   = 3'd6;

endpackage

// File: rtl/huff_sample_cnt.sv
// Saturating gray-sample counter with a frame-complete flag.
module huff_sample_cnt
  import huffman_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = NUM_SAMPLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic done,
  output logic at_last_c
);

  localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1);

  logic [CNT_W-1:0] cnt;

  // Next accepted sample completes the frame
  assign at_last_c = (cnt == CNT_W'(NUM_SAMPLES - 1));

  // Count accepted samples; hold once the frame is complete
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (inc && !done) begin
      cnt  <= cnt + CNT_W'(1);
      done <= at_last_c;
    end
  end

endmodule

// File: rtl/huffman_ctrl.sv
// Top-level sequencer: sample counting, sort/combine rounds, split rounds, decode.
module huffman_ctrl
  import huffman_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = NUM_SAMPLES_DEF,
  parameter int unsigned NUM_SYMS    = NUM_SYMS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gray_valid,
  input  logic       sort_done,
  output logic [2:0] state,
  output logic       cnt_en,
  output logic       sort_start,
  output logic       combine_en,
  output logic       split_en,
  output logic [2:0] round,
  output logic       code_valid,
  output logic       busy
);

  localparam logic [2:0] LAST_ROUND = 3'(NUM_SYMS - 3);

  logic [2:0] state_nxt;
  logic [2:0] round_nxt;
  logic       sort_start_nxt;
  logic       cnt_clr;
  logic       cnt_done;
  logic       cnt_last;

  huff_sample_cnt #(
    .NUM_SAMPLES (NUM_SAMPLES)
  ) u_sample_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc       (cnt_en),
    .clr       (cnt_clr),
    .done      (cnt_done),
    .at_last_c (cnt_last)
  );

  // Sample acceptance: only while collecting and before the frame is full
  assign cnt_en = gray_valid && ((state == ST_IDLE) || (state == ST_COUNT)) && !cnt_done;

  // Strobes decoded from the registered state only
  assign combine_en = (state == ST_COMBINE);
  assign split_en   = (state == ST_SPLIT);
  assign code_valid = (state == ST_CODEV);
  assign busy       = (state != ST_IDLE);

  // State, round and start-pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      round      <= 3'd0;
      sort_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      round      <= round_nxt;
      sort_start <= sort_start_nxt;
    end
  end

  // Next-state, round update and start-pulse generation
  always_comb begin
    state_nxt      = state;
    round_nxt      = round;
    sort_start_nxt = 1'b0;
    cnt_clr        = 1'b0;
    case (state)
      ST_IDLE, ST_COUNT: begin
        if (cnt_en) begin
          if (cnt_last) begin
            state_nxt      = ST_SORT;
            sort_start_nxt = 1'b1;
          end else begin
            state_nxt = ST_COUNT;
          end
        end
      end
      ST_SORT: begin
        // sort_start marks the first SORT cycle, whose sort_done is stale
        if (sort_done && !sort_start) begin
          state_nxt = ST_COMBINE;
        end
      end
      ST_COMBINE: begin
        if (round == LAST_ROUND) begin
          state_nxt = ST_SPLIT;
        end else begin
          round_nxt      = round + 3'd1;
          state_nxt      = ST_SORT;
          sort_start_nxt = 1'b1;
        end
      end
      ST_SPLIT: begin
        if (round == 3'd0) begin
          state_nxt = ST_DECODE;
        end else begin
          round_nxt = round - 3'd1;
        end
      end
      ST_DECODE: begin
        state_nxt = ST_CODEV;
      end
      ST_CODEV: begin
        state_nxt = ST_IDLE;
        round_nxt = 3'd0;
        cnt_clr   = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        round_nxt = 3'd0;
        cnt_clr   = 1'b1;
      end
    endcase
  end

endmodule
